dma_multichannel: RTL and testbench

Multi-channel successor to the single-channel CHERIoT DMA engine. It has NumChannels independent register sets that share one bus master port, arbitrated round-robin one word at a time. Each channel copies strided 33-bit words (data plus capability tag) with optional byte swapping. A channel aborts itself when a snooped tsmap read shows that its source or target heap granule is revoked. The block sits beside the core on the config OBI bus and the system bus, and snoops the core's tsmap port.

---
 rtl/dma_multichannel_if.sv | 16 +
 rtl/dma_multichannel.sv | 240 ++++++++++++++++++++++++
 tb/tb_dma_multichannel.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_multichannel_if.sv
// Bus master port shared by all DMA channels.
// Each word carries 32 data bits plus a capability tag in bit 32.
interface dma_multichannel_if;
  logic        req;
  logic        gnt;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [32:0] wdata;
  logic [32:0] rdata;
  logic        rvalid;
  logic        err;

  modport master (output req, we, addr, be, wdata, input gnt, rdata, rvalid, err);
  modport slave  (input req, we, addr, be, wdata, output gnt, rdata, rvalid, err);
endinterface

// File: rtl/dma_multichannel.sv
// Multi-channel tagged-word DMA. Channels share one bus master, one word at a time,
// round-robin, and abort themselves when a snooped tsmap read revokes their heap granule.
module dma_multichannel #(
  parameter int          NumChannels = 2,
  parameter logic [31:0] HeapBase    = 32'h2000_0000,
  parameter int          TSMapSize   = 2048
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   conf_en_i,
  input  logic [31:0]            conf_addr_i,
  input  logic                   conf_we_i,
  input  logic [31:0]            conf_wdata_i,
  output logic                   conf_ready_o,
  output logic [31:0]            conf_rdata_o,
  output logic [NumChannels-1:0] dma_irq_o,
  dma_multichannel_if.master     bus,
  input  logic                   snoop_tsmap_cs_i,
  input  logic [15:0]            snoop_tsmap_addr_i,
  input  logic [31:0]            snoop_tsmap_rdata_i
);
  localparam int CW = (NumChannels > 1) ? $clog2(NumChannels) : 1;

  // state   | meaning
  // ARB     | choose next busy channel after the last one served
  // RD_REQ  | read request at cur_src held until granted
  // RD_WAIT | waiting for read data (discarded if the channel died)
  // WR_REQ  | write request at cur_dst held until granted
  typedef enum logic [1:0] {ARB, RD_REQ, RD_WAIT, WR_REQ} state_e;

  logic [NumChannels-1:0] busy_q, done_q, revoked_q, buserr_q, swap16_q, swap32_q;
  logic [31:0] src_q [NumChannels];
  logic [31:0] dst_q [NumChannels];
  logic [31:0] len_q [NumChannels];
  logic [31:0] sstr_q [NumChannels];
  logic [31:0] dstr_q [NumChannels];
  logic [31:0] cur_src_q [NumChannels];
  logic [31:0] cur_dst_q [NumChannels];
  logic [29:0] remaining_q [NumChannels];

  state_e                 state_q;
  logic [CW-1:0]          act_q, last_q;
  logic                   discard_q;
  logic [NumChannels-1:0] irq_q;
  logic [31:0]            rdata_q;
  logic                   req_q, we_q;
  logic [31:0]            addr_q;
  logic [32:0]            wdata_q;

  assign conf_ready_o = 1'b1;
  assign conf_rdata_o = rdata_q;
  assign dma_irq_o    = irq_q;
  assign bus.req      = req_q;
  assign bus.we       = we_q;
  assign bus.addr     = addr_q;
  assign bus.be       = 4'hf;
  assign bus.wdata    = wdata_q;

  logic [2:0]    conf_word, conf_chan;
  logic [CW-1:0] cch;
  logic          conf_hit, wr_hit;
  logic          unused_addr_bits;

  assign conf_word        = conf_addr_i[4:2];
  assign conf_chan        = conf_addr_i[7:5];
  assign cch              = conf_chan[CW-1:0];
  assign conf_hit         = conf_en_i && (int'(conf_chan) < NumChannels) && (conf_word != 3'd7);
  assign wr_hit           = conf_hit && conf_we_i;
  assign unused_addr_bits = ^{conf_addr_i[31:8], conf_addr_i[1:0]};

  logic [31:0] rd_mux;
  always_comb begin
    rd_mux = '0;
    if (conf_hit) begin
      case (conf_word)
        3'd0: rd_mux = {29'b0, swap32_q[cch], swap16_q[cch], 1'b0};
        3'd1: rd_mux = {28'b0, buserr_q[cch], revoked_q[cch], done_q[cch], busy_q[cch]};
        3'd2: rd_mux = src_q[cch];
        3'd3: rd_mux = dst_q[cch];
        3'd4: rd_mux = len_q[cch];
        3'd5: rd_mux = sstr_q[cch];
        3'd6: rd_mux = dstr_q[cch];
        default: rd_mux = '0;
      endcase
    end
  end

  // Granule index comes from the programmed base address, not the moving cursor.
  function automatic logic granule_hit(input logic [31:0] a, input logic [15:0] widx,
                                       input logic [31:0] map);
    logic [31:0] off;
    off = a - HeapBase;
    return (a >= HeapBase) && ({8'b0, off[31:8]} < 32'(TSMapSize)) &&
           (off[23:8] == widx) && map[off[7:3]];
  endfunction

  logic [NumChannels-1:0] rev_hit, abort_now;
  always_comb begin
    rev_hit   = '0;
    abort_now = '0;
    for (int c = 0; c < NumChannels; c++) begin
      rev_hit[c]   = busy_q[c] && snoop_tsmap_cs_i &&
                     (granule_hit(src_q[c], snoop_tsmap_addr_i, snoop_tsmap_rdata_i) ||
                      granule_hit(dst_q[c], snoop_tsmap_addr_i, snoop_tsmap_rdata_i));
      abort_now[c] = wr_hit && (conf_word == 3'd0) && (int'(conf_chan) == c) &&
                     conf_wdata_i[3] && busy_q[c];
    end
  end

  logic          pick_found;
  logic [CW-1:0] pick_ch;
  int            idx;
  always_comb begin
    pick_found = 1'b0;
    pick_ch    = '0;
    idx        = 0;
    for (int i = 1; i <= NumChannels; i++) begin
      idx = int'(last_q) + i;
      if (idx >= NumChannels) idx = idx - NumChannels;
      if (!pick_found && busy_q[idx] && (remaining_q[idx] != '0)) begin
        pick_found = 1'b1;
        pick_ch    = idx[CW-1:0];
      end
    end
  end

  logic        kill;
  logic [32:0] swapped;
  assign kill = rev_hit[act_q] || abort_now[act_q] || !busy_q[act_q];

  always_comb begin
    if (swap16_q[act_q])
      swapped = {17'b0, bus.rdata[7:0], bus.rdata[15:8]};
    else if (swap32_q[act_q])
      swapped = {1'b0, bus.rdata[7:0], bus.rdata[15:8], bus.rdata[23:16], bus.rdata[31:24]};
    else
      swapped = bus.rdata;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0; done_q <= '0; revoked_q <= '0; buserr_q <= '0;
      swap16_q <= '0; swap32_q <= '0;
      for (int c = 0; c < NumChannels; c++) begin
        src_q[c] <= '0; dst_q[c] <= '0; len_q[c] <= '0; sstr_q[c] <= '0; dstr_q[c] <= '0;
        cur_src_q[c] <= '0; cur_dst_q[c] <= '0; remaining_q[c] <= '0;
      end
      state_q <= ARB; act_q <= '0; last_q <= '0; discard_q <= 1'b0;
      irq_q <= '0; rdata_q <= '0; req_q <= 1'b0; we_q <= 1'b0; addr_q <= '0; wdata_q <= '0;
    end else begin
      irq_q <= '0;
      if (conf_en_i && !conf_we_i) rdata_q <= rd_mux;

      // Zero-length starts finish one cycle after being started.
      for (int c = 0; c < NumChannels; c++) begin
        if (busy_q[c] && remaining_q[c] == '0) begin
          busy_q[c] <= 1'b0; done_q[c] <= 1'b1; irq_q[c] <= 1'b1;
        end
      end

      if (wr_hit) begin
        case (conf_word)
          3'd0: begin
            swap16_q[cch] <= conf_wdata_i[1];
            swap32_q[cch] <= conf_wdata_i[2];
            if (conf_wdata_i[0] && !busy_q[cch]) begin
              busy_q[cch]      <= 1'b1;
              done_q[cch]      <= 1'b0;
              revoked_q[cch]   <= 1'b0;
              buserr_q[cch]    <= 1'b0;
              cur_src_q[cch]   <= src_q[cch];
              cur_dst_q[cch]   <= dst_q[cch];
              remaining_q[cch] <= len_q[cch][31:2];
            end else if (conf_wdata_i[3] && busy_q[cch]) begin
              busy_q[cch] <= 1'b0;
            end
          end
          3'd1: begin
            if (conf_wdata_i[1]) done_q[cch]    <= 1'b0;
            if (conf_wdata_i[2]) revoked_q[cch] <= 1'b0;
            if (conf_wdata_i[3]) buserr_q[cch]  <= 1'b0;
          end
          3'd2: if (!busy_q[cch]) src_q[cch]  <= conf_wdata_i;
          3'd3: if (!busy_q[cch]) dst_q[cch]  <= conf_wdata_i;
          3'd4: if (!busy_q[cch]) len_q[cch]  <= conf_wdata_i;
          3'd5: if (!busy_q[cch]) sstr_q[cch] <= conf_wdata_i;
          3'd6: if (!busy_q[cch]) dstr_q[cch] <= conf_wdata_i;
          default: ;
        endcase
      end

      case (state_q)
        ARB: if (pick_found) begin
          act_q <= pick_ch; last_q <= pick_ch; discard_q <= 1'b0;
          req_q <= 1'b1; we_q <= 1'b0; addr_q <= cur_src_q[pick_ch];
          state_q <= RD_REQ;
        end
        RD_REQ: if (bus.gnt) begin
          req_q <= 1'b0; discard_q <= kill; state_q <= RD_WAIT;
        end else if (kill) begin
          req_q <= 1'b0; state_q <= ARB;
        end
        RD_WAIT: begin
          if (kill) discard_q <= 1'b1;
          if (bus.rvalid) begin
            if (discard_q || kill) begin
              state_q <= ARB;
            end else if (bus.err) begin
              buserr_q[act_q] <= 1'b1; busy_q[act_q] <= 1'b0; irq_q[act_q] <= 1'b1;
              state_q <= ARB;
            end else begin
              wdata_q <= swapped; addr_q <= cur_dst_q[act_q];
              req_q <= 1'b1; we_q <= 1'b1; state_q <= WR_REQ;
            end
          end
        end
        WR_REQ: if (kill) begin
          req_q <= 1'b0; we_q <= 1'b0; state_q <= ARB;
        end else if (bus.gnt) begin
          req_q <= 1'b0; we_q <= 1'b0; state_q <= ARB;
          cur_src_q[act_q]   <= cur_src_q[act_q] + 32'd4 + sstr_q[act_q];
          cur_dst_q[act_q]   <= cur_dst_q[act_q] + 32'd4 + dstr_q[act_q];
          remaining_q[act_q] <= remaining_q[act_q] - 30'd1;
          if (remaining_q[act_q] == 30'd1) begin
            busy_q[act_q] <= 1'b0; done_q[act_q] <= 1'b1; irq_q[act_q] <= 1'b1;
          end
        end
        default: state_q <= ARB;
      endcase

      // Revocation overrides any completion or bus error in the same cycle.
      for (int c = 0; c < NumChannels; c++) begin
        if (rev_hit[c]) begin
          revoked_q[c] <= 1'b1; busy_q[c] <= 1'b0; irq_q[c] <= 1'b1;
          done_q[c] <= 1'b0; buserr_q[c] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_dma_multichannel.sv
// Scoreboard bench for dma_multichannel: expected bus transactions are queued by the
// stimulus and popped by a monitor; a responder plays the bus slave.
module tb_dma_multichannel;
  logic        clk = 1'b0;
  logic        rst;
  logic        conf_en, conf_we, conf_ready;
  logic [31:0] conf_addr, conf_wdata, conf_rdata;
  logic [1:0]  irq;
  logic        snoop_cs;
  logic [15:0] snoop_addr;
  logic [31:0] snoop_rdata;

  always #5 clk = ~clk;

  dma_multichannel_if bus();

  dma_multichannel #(.NumChannels(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .conf_en_i(conf_en), .conf_addr_i(conf_addr), .conf_we_i(conf_we),
    .conf_wdata_i(conf_wdata), .conf_ready_o(conf_ready), .conf_rdata_o(conf_rdata),
    .dma_irq_o(irq), .bus(bus),
    .snoop_tsmap_cs_i(snoop_cs), .snoop_tsmap_addr_i(snoop_addr),
    .snoop_tsmap_rdata_i(snoop_rdata)
  );

  typedef struct packed {logic we; logic [31:0] addr; logic [32:0] data;} txn_t;
  txn_t exp_q[$];
  txn_t mon_e;

  int   n_cmp = 0, n_bad = 0;
  int   irq_cnt [2] = '{0, 0};
  logic [1:0] irq_prev = '0;
  logic block_wr = 1'b0;
  int   rd_lat = 0, rd_wait = 0, rd_num = 0, err_at = 0;
  bit   rd_pend = 0, rd_err = 0, saw_rev_rd = 0, saw_wr = 0;
  logic [31:0] rd_addr;
  logic [32:0] mem [logic [31:0]];

  assign bus.gnt = !(block_wr && bus.we);

  function automatic logic [32:0] mem_val(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[2], a ^ 32'h5A5A_0000};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus slave: grant per block_wr, read data after rd_lat+1 cycles.
  initial begin
    bus.rvalid = 1'b0; bus.err = 1'b0; bus.rdata = '0;
    forever begin
      @(negedge clk);
      bus.rvalid = 1'b0; bus.err = 1'b0;
      if (rd_pend) begin
        if (rd_wait == 0) begin
          bus.rvalid = 1'b1; bus.rdata = mem_val(rd_addr); bus.err = rd_err; rd_pend = 0;
        end else rd_wait--;
      end
      if (!rst && bus.req && bus.gnt && !bus.we) begin
        rd_num++;
        rd_pend = 1; rd_addr = bus.addr; rd_wait = rd_lat; rd_err = (rd_num == err_at);
      end
    end
  end

  // Monitor: every accepted transfer must match the head of the expected queue.
  initial forever begin
    @(negedge clk);
    if (!rst && bus.req && bus.we) saw_wr = 1;
    if (!rst && bus.req && bus.gnt) begin
      if (!bus.we && bus.addr == 32'h2000_0040) saw_rev_rd = 1;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL bus_txn: unexpected we=%b addr=%h wdata=%h, expected none", bus.we, bus.addr, bus.wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.we !== mon_e.we || bus.addr !== mon_e.addr || (mon_e.we && bus.wdata !== mon_e.data)) begin
          n_bad++;
          $display("FAIL bus_txn: got we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                   bus.we, bus.addr, bus.wdata, mon_e.we, mon_e.addr, mon_e.data);
        end
      end
    end
    for (int c = 0; c < 2; c++) begin
      if (irq[c]) begin
        n_cmp++;
        if (irq_prev[c]) begin
          n_bad++;
          $display("FAIL irq_width ch%0d: got high 2 cycles expected 1", c);
        end
        irq_cnt[c]++;
      end
    end
    irq_prev = irq;
  end

  task automatic conf_wr(input logic [31:0] a, input logic [31:0] d);
    conf_en = 1; conf_we = 1; conf_addr = a; conf_wdata = d;
    @(negedge clk);
    conf_en = 0; conf_we = 0;
  endtask

  task automatic conf_rd(input logic [31:0] a, output logic [31:0] d);
    conf_en = 1; conf_we = 0; conf_addr = a;
    @(negedge clk);
    conf_en = 0;
    d = conf_rdata;
  endtask

  task automatic setup(input int ch, input logic [31:0] s, input logic [31:0] d,
                       input logic [31:0] len, input logic [31:0] ss, input logic [31:0] ds);
    conf_wr(32'(ch * 32) + 8, s);
    conf_wr(32'(ch * 32) + 12, d);
    conf_wr(32'(ch * 32) + 16, len);
    conf_wr(32'(ch * 32) + 20, ss);
    conf_wr(32'(ch * 32) + 24, ds);
  endtask

  task automatic push(input logic we, input logic [31:0] a, input logic [32:0] d);
    exp_q.push_back('{we: we, addr: a, data: d});
  endtask

  task automatic push_pair(input logic [31:0] s, input logic [31:0] d);
    push(0, s, '0);
    push(1, d, mem_val(s));
  endtask

  task automatic start(input int ch, input logic [31:0] ctrl);
    conf_wr(32'(ch * 32), ctrl);
  endtask

  task automatic wait_idle(input int ch);
    logic [31:0] s;
    int b;
    s = 32'h1; b = 0;
    while (s[0] && b < 300) begin
      conf_rd(32'(ch * 32) + 4, s);
      b++;
    end
    if (s[0]) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout ch%0d: got busy=1 expected busy=0", ch);
    end
  endtask

  task automatic check_status(input string name, input int ch, input logic [31:0] exp);
    logic [31:0] s;
    conf_rd(32'(ch * 32) + 4, s);
    check(name, s, exp);
  endtask

  logic [31:0] rv;
  int          b;

  initial begin
    rst = 1; conf_en = 0; conf_we = 0; conf_addr = '0; conf_wdata = '0;
    snoop_cs = 0; snoop_addr = '0; snoop_rdata = '0;
    mem[32'h2000_0500] = 33'h1_1122_3344;
    repeat (3) @(negedge clk);
    check("rst_req", bus.req, 0);
    check("rst_we", bus.we, 0);
    check("rst_addr", bus.addr, 0);
    check("rst_wdata", bus.wdata, 0);
    check("rst_irq", irq, 0);
    check("rst_rdata", conf_rdata, 0);
    rst = 0;
    @(negedge clk);
    check_status("rst_status0", 0, 0);

    // Single channel, 4 words, zero strides.
    setup(0, 32'h2000_0100, 32'h2000_0200, 16, 0, 0);
    for (int i = 0; i < 4; i++) push_pair(32'h2000_0100 + 32'(4 * i), 32'h2000_0200 + 32'(4 * i));
    start(0, 1);
    wait_idle(0);
    check_status("basic_status", 0, 32'h2);
    check("basic_irq0", irq_cnt[0], 1);
    check("basic_irq1", irq_cnt[1], 0);
    check("basic_q", exp_q.size(), 0);

    // Two channels interleave word by word; ch1 uses a source stride of 4.
    setup(0, 32'h2000_1000, 32'h2000_1100, 8, 0, 0);
    setup(1, 32'h2000_0300, 32'h2000_0400, 8, 4, 0);
    push_pair(32'h2000_1000, 32'h2000_1100);
    push_pair(32'h2000_0300, 32'h2000_0400);
    push_pair(32'h2000_1004, 32'h2000_1104);
    push_pair(32'h2000_0308, 32'h2000_0404);
    start(0, 1);
    start(1, 1);
    wait_idle(0);
    wait_idle(1);
    check_status("rr_status0", 0, 32'h2);
    check_status("rr_status1", 1, 32'h2);
    check("rr_irq0", irq_cnt[0], 2);
    check("rr_irq1", irq_cnt[1], 1);
    check("rr_q", exp_q.size(), 0);

    // Byte swapping and tag handling.
    setup(0, 32'h2000_0500, 32'h2000_0600, 4, 0, 0);
    push(0, 32'h2000_0500, '0); push(1, 32'h2000_0600, 33'h0_4433_2211);
    start(0, 32'h5);
    wait_idle(0);
    push(0, 32'h2000_0500, '0); push(1, 32'h2000_0600, 33'h1_1122_3344);
    start(0, 32'h1);
    wait_idle(0);
    push(0, 32'h2000_0500, '0); push(1, 32'h2000_0600, 33'h0_0000_4433);
    start(0, 32'h7);
    wait_idle(0);
    conf_rd(32'h0, rv);
    check("ctrl_readback", rv, 32'h6);
    check("swap_irq0", irq_cnt[0], 5);
    check("swap_q", exp_q.size(), 0);

    // Revocation of ch1 while its read is outstanding; ch0 carries on.
    setup(0, 32'h2000_0800, 32'h2000_0900, 8, 0, 0);
    setup(1, 32'h2000_0040, 32'h2000_0700, 8, 0, 0);
    rd_lat = 4; saw_rev_rd = 0;
    push_pair(32'h2000_0800, 32'h2000_0900);
    push(0, 32'h2000_0040, '0);
    push_pair(32'h2000_0804, 32'h2000_0904);
    start(0, 1);
    start(1, 1);
    b = 0;
    while (!saw_rev_rd && b < 300) begin @(negedge clk); b++; end
    if (!saw_rev_rd) begin
      n_cmp++; n_bad++;
      $display("FAIL rev_read_timeout: got no read at 20000040 expected one");
    end
    snoop_cs = 1; snoop_addr = 16'h0; snoop_rdata = 32'h100;
    @(negedge clk);
    snoop_cs = 0; snoop_rdata = '0;
    wait_idle(0);
    wait_idle(1);
    repeat (8) @(negedge clk);
    check_status("rev_status1", 1, 32'h4);
    check_status("rev_status0", 0, 32'h2);
    check("rev_irq1", irq_cnt[1], 2);
    check("rev_irq0", irq_cnt[0], 6);
    check("rev_q", exp_q.size(), 0);
    rd_lat = 0;

    // Zero-length transfer: done with no bus traffic.
    setup(0, 32'h2000_0C00, 32'h2000_0D00, 0, 0, 0);
    start(0, 1);
    wait_idle(0);
    repeat (3) @(negedge clk);
    check_status("len0_status", 0, 32'h2);
    check("len0_irq0", irq_cnt[0], 7);
    check("len0_q", exp_q.size(), 0);

    // Bus error on the second read: exactly one write issued.
    setup(0, 32'h2000_0A00, 32'h2000_0B00, 16, 0, 0);
    rd_num = 0; err_at = 2;
    push_pair(32'h2000_0A00, 32'h2000_0B00);
    push(0, 32'h2000_0A04, '0);
    start(0, 1);
    wait_idle(0);
    repeat (3) @(negedge clk);
    err_at = 0;
    check_status("buserr_status", 0, 32'h8);
    check("buserr_irq0", irq_cnt[0], 8);
    check("buserr_q", exp_q.size(), 0);

    // Base registers are frozen while busy.
    setup(0, 32'h2000_0E00, 32'h2000_0F00, 8, 0, 0);
    rd_lat = 6;
    push_pair(32'h2000_0E00, 32'h2000_0F00);
    push_pair(32'h2000_0E04, 32'h2000_0F04);
    start(0, 1);
    conf_wr(32'h8, 32'hDEAD_BEEF);
    conf_rd(32'h8, rv);
    check("src_locked", rv, 32'h2000_0E00);
    wait_idle(0);
    check_status("locked_status", 0, 32'h2);
    check("locked_irq0", irq_cnt[0], 9);
    rd_lat = 0;

    // Reset while a write request is stalled.
    block_wr = 1; saw_wr = 0;
    setup(1, 32'h2000_1200, 32'h2000_1300, 16, 0, 0);
    push(0, 32'h2000_1200, '0);
    start(1, 1);
    b = 0;
    while (!saw_wr && b < 300) begin @(negedge clk); b++; end
    if (!saw_wr) begin
      n_cmp++; n_bad++;
      $display("FAIL wr_req_timeout: got no write request expected one");
    end
    rst = 1;
    @(negedge clk);
    check("midrst_req", bus.req, 0);
    check("midrst_irq", irq, 0);
    rst = 0; block_wr = 0;
    check_status("midrst_status0", 0, 0);
    check_status("midrst_status1", 1, 0);
    conf_rd(32'h28, rv);
    check("midrst_src1", rv, 0);
    repeat (5) @(negedge clk);
    check("midrst_irq1_total", irq_cnt[1], 2);
    check("final_q", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
